// File: rtl/hack_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : hack_memory_responder
// Description : HACK CPU data-memory responder. Provides RAM, screen and KBD
//               decode, a registered screen scanner port and a held keyboard
//               register. Screen storage is built only when the macro
//               HACK_MEM_SCREEN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_memory_responder #(
    parameter int KBD_HOLD = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_code,
    output logic        kbd_ready,
    input  logic        scr_rd,
    input  logic [12:0] scr_addr,
    output logic [15:0] scr_data,
    output logic        scr_valid,
    output logic        oob_err
);

    localparam int c_CW = (KBD_HOLD < 1) ? 1 : $clog2(KBD_HOLD + 1);
    localparam logic [c_CW-1:0] c_HOLD = c_CW'(KBD_HOLD);

    logic            w_is_ram;
    logic            w_is_scr;
    logic            w_is_kbd;
    logic            w_is_oob;
    logic            w_hold_zero;
    logic            w_accept;
    logic [15:0]     w_scr_rdata;

    logic [15:0]     r_ram [0:16383];
    logic [15:0]     r_kbd;
    logic [c_CW-1:0] r_hold_cnt;
    logic            r_oob_err;

    assign w_is_ram = ~addressM[14];
    assign w_is_scr = (addressM[14:13] == 2'b10);
    assign w_is_kbd = (addressM == 15'd24576);
    assign w_is_oob = (addressM[14:13] == 2'b11) && (addressM[12:0] != 13'd0);

    // Acceptance needs no reset term: flops cannot update while reset_n is low.
    assign w_hold_zero = (r_hold_cnt == '0);
    assign w_accept    = kbd_valid && w_hold_zero;
    assign kbd_ready   = reset_n && w_hold_zero;
    assign oob_err     = r_oob_err;

    always_ff @(posedge clk) begin
        if (writeM && w_is_ram) begin
            r_ram[addressM[13:0]] <= outM;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_kbd      <= 16'd0;
            r_hold_cnt <= '0;
            r_oob_err  <= 1'b0;
        end else begin
            if (w_is_oob) begin
                r_oob_err <= 1'b1;
            end
            if (w_accept) begin
                r_kbd <= kbd_code;
                if (kbd_code != 16'd0) begin
                    r_hold_cnt <= c_HOLD;
                end
            end else if (!w_hold_zero) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end
        end
    end

`ifdef HACK_MEM_SCREEN_EN
    logic [15:0] r_scr [0:8191];
    logic [15:0] r_scr_data;
    logic        r_scr_valid;

    always_ff @(posedge clk) begin
        if (writeM && w_is_scr) begin
            r_scr[addressM[12:0]] <= outM;
        end
    end

    // Non-blocking read of the array gives read-before-write on a same-word collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scr_data  <= 16'd0;
            r_scr_valid <= 1'b0;
        end else begin
            r_scr_valid <= scr_rd;
            if (scr_rd) begin
                r_scr_data <= r_scr[scr_addr];
            end
        end
    end

    assign w_scr_rdata = r_scr[addressM[12:0]];
    assign scr_data    = r_scr_data;
    assign scr_valid   = r_scr_valid;
`else
    logic w_unused_scr;

    assign w_unused_scr = ^{scr_rd, scr_addr};
    assign w_scr_rdata  = 16'd0;
    assign scr_data     = 16'd0;
    assign scr_valid    = 1'b0;
`endif

    always_comb begin
        inM = 16'd0;
        if (w_is_ram) begin
            inM = r_ram[addressM[13:0]];
        end else if (w_is_scr) begin
            inM = w_scr_rdata;
        end else if (w_is_kbd) begin
            inM = r_kbd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hack_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_memory_responder
// Description : Scoreboard bench for hack_memory_responder (KBD_HOLD = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_memory_responder;

    localparam int c_K_INM    = 0;
    localparam int c_K_RDY    = 1;
    localparam int c_K_OOB    = 2;
    localparam int c_K_SDATA  = 3;
    localparam int c_K_SVALID = 4;

    typedef struct {
        int          kind;
        string       name;
        logic [15:0] exp;
    } chk_t;

    logic        clk;
    logic        reset_n;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        kbd_ready;
    logic        scr_rd;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_valid;
    logic        oob_err;

    int          n_checks;
    int          n_errors;
    chk_t        q_now[$];
    logic [15:0] q_scr[$];

    hack_memory_responder #(.KBD_HOLD(4)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addressM  (addressM),
        .outM      (outM),
        .writeM    (writeM),
        .inM       (inM),
        .kbd_valid (kbd_valid),
        .kbd_code  (kbd_code),
        .kbd_ready (kbd_ready),
        .scr_rd    (scr_rd),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data),
        .scr_valid (scr_valid),
        .oob_err   (oob_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expect_now(input int kind, input string name, input logic [15:0] exp);
        chk_t c;
        c.kind = kind;
        c.name = name;
        c.exp  = exp;
        q_now.push_back(c);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: drains pending expectations and scores every scanner response.
    always @(negedge clk) begin
        chk_t        c;
        logic [15:0] act;
        while (q_now.size() > 0) begin
            c = q_now.pop_front();
            case (c.kind)
                c_K_INM:    act = inM;
                c_K_RDY:    act = {15'd0, kbd_ready};
                c_K_OOB:    act = {15'd0, oob_err};
                c_K_SDATA:  act = scr_data;
                default:    act = {15'd0, scr_valid};
            endcase
            check(c.name, act, c.exp);
        end
        if (scr_valid !== 1'b0) begin
            if (q_scr.size() == 0) begin
                check("scr_valid_spurious", {15'd0, scr_valid}, 16'd0);
            end else begin
                check("scr_data", scr_data, q_scr.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        addressM  = 15'd24576;
        outM      = 16'd0;
        writeM    = 1'b0;
        kbd_valid = 1'b0;
        kbd_code  = 16'd0;
        scr_rd    = 1'b0;
        scr_addr  = 13'd0;

        cyc();
        cyc();
        expect_now(c_K_RDY,    "rst_kbd_ready", 16'd0);
        expect_now(c_K_OOB,    "rst_oob_err",   16'd0);
        expect_now(c_K_SVALID, "rst_scr_valid", 16'd0);
        expect_now(c_K_SDATA,  "rst_scr_data",  16'd0);
        expect_now(c_K_INM,    "rst_kbd_reg",   16'd0);
        cyc();
        reset_n = 1'b1;
        expect_now(c_K_RDY, "post_rst_ready", 16'd1);
        expect_now(c_K_INM, "post_rst_kbd",   16'd0);

        // RAM write / read-back
        cyc();
        addressM = 15'd5; outM = 16'h1234; writeM = 1'b1;
        cyc();
        addressM = 15'd1; outM = 16'h1111;
        cyc();
        writeM = 1'b0; addressM = 15'd5;
        expect_now(c_K_INM, "ram_read_5", 16'h1234);
        cyc();
        addressM = 15'd1;
        expect_now(c_K_INM, "ram_read_1", 16'h1111);

`ifdef HACK_MEM_SCREEN_EN
        cyc();
        addressM = 15'd16384; outM = 16'h5555; writeM = 1'b1;
        cyc();
        outM = 16'hAAAA; scr_rd = 1'b1; scr_addr = 13'd0;
        q_scr.push_back(16'h5555);
        cyc();
        writeM = 1'b0;
        q_scr.push_back(16'hAAAA);
        cyc();
        scr_rd = 1'b0; writeM = 1'b1; addressM = 15'd16385; outM = 16'h0101;
        cyc();
        addressM = 15'd24575; outM = 16'h0202;
        cyc();
        writeM = 1'b0; addressM = 15'd16384;
        scr_rd = 1'b1; scr_addr = 13'd1;
        q_scr.push_back(16'h0101);
        expect_now(c_K_INM, "scr_cpu_read", 16'hAAAA);
        cyc();
        scr_addr = 13'd8191;
        q_scr.push_back(16'h0202);
        expect_now(c_K_OOB, "scr_top_not_oob", 16'd0);
        cyc();
        scr_rd = 1'b0;
        cyc();
        expect_now(c_K_SDATA,  "scr_data_hold", 16'h0202);
        expect_now(c_K_SVALID, "scr_valid_low", 16'd0);
`else
        cyc();
        addressM = 15'd20000; outM = 16'hFFFF; writeM = 1'b1;
        scr_rd = 1'b1; scr_addr = 13'd0;
        cyc();
        writeM = 1'b0; scr_rd = 1'b0;
        expect_now(c_K_INM,   "noscr_read",  16'd0);
        expect_now(c_K_OOB,   "noscr_oob",   16'd0);
        expect_now(c_K_SDATA, "noscr_sdata", 16'd0);
        cyc();
        expect_now(c_K_SVALID, "noscr_svalid", 16'd0);
`endif

        // Keyboard hold: accept 65, hold 4 cycles, then accept 0
        cyc();
        addressM = 15'd24576; kbd_valid = 1'b1; kbd_code = 16'd65;
        expect_now(c_K_RDY, "kbd_ready_idle", 16'd1);
        expect_now(c_K_INM, "kbd_before",     16'd0);
        cyc();
        kbd_code = 16'd0;
        expect_now(c_K_RDY, "kbd_hold_0", 16'd0);
        expect_now(c_K_INM, "kbd_65",     16'd65);
        for (int i = 1; i < 4; i++) begin
            cyc();
            expect_now(c_K_RDY, $sformatf("kbd_hold_%0d", i), 16'd0);
            expect_now(c_K_INM, "kbd_65_held", 16'd65);
        end
        cyc();
        expect_now(c_K_RDY, "kbd_hold_end", 16'd1);
        expect_now(c_K_INM, "kbd_65_last",  16'd65);
        cyc();
        kbd_valid = 1'b0;
        expect_now(c_K_INM, "kbd_zero_acc", 16'd0);
        expect_now(c_K_RDY, "kbd_zero_nohold", 16'd1);

        // KBD write ignored; OOB write ignored and flagged
        cyc();
        kbd_valid = 1'b1; kbd_code = 16'h0042;
        cyc();
        kbd_valid = 1'b0;
        writeM = 1'b1; outM = 16'h7777;
        expect_now(c_K_INM, "kbd_42", 16'h0042);
        cyc();
        writeM = 1'b0;
        expect_now(c_K_INM, "kbd_write_ignored", 16'h0042);
        expect_now(c_K_OOB, "kbd_not_oob",       16'd0);
        cyc();
        addressM = 15'd24577; writeM = 1'b1; outM = 16'hBEEF;
        expect_now(c_K_INM, "oob_read_zero", 16'd0);
        expect_now(c_K_OOB, "oob_before",    16'd0);
        cyc();
        writeM = 1'b0; addressM = 15'd1;
        expect_now(c_K_OOB, "oob_set",       16'd1);
        expect_now(c_K_INM, "oob_write_ign", 16'h1111);
        for (int i = 0; i < 4; i++) cyc();
        expect_now(c_K_OOB, "oob_sticky", 16'd1);
        expect_now(c_K_RDY, "kbd_ready_again", 16'd1);

        // Reset in the middle of a hold
        cyc();
        addressM = 15'd24576; kbd_valid = 1'b1; kbd_code = 16'h0051;
        cyc();
        expect_now(c_K_RDY, "mid_hold_ready", 16'd0);
        expect_now(c_K_INM, "kbd_51",         16'h0051);
        cyc();
        reset_n = 1'b0; kbd_valid = 1'b0;
        expect_now(c_K_RDY, "mid_rst_ready", 16'd0);
        expect_now(c_K_INM, "mid_rst_kbd",   16'd0);
        expect_now(c_K_OOB, "mid_rst_oob",   16'd0);
        cyc();
        reset_n = 1'b1; kbd_valid = 1'b1; kbd_code = 16'h0033;
        expect_now(c_K_RDY, "rel_ready", 16'd1);
        cyc();
        kbd_valid = 1'b0;
        expect_now(c_K_INM, "kbd_33_first_edge", 16'h0033);
        expect_now(c_K_RDY, "kbd_33_hold",       16'd0);

        // OOB by read alone
        cyc();
        addressM = 15'd32767;
        cyc();
        addressM = 15'd5;
        expect_now(c_K_OOB, "oob_read_sets", 16'd1);

        cyc();
        cyc();
        check("scr_queue_drained", 16'(q_scr.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
